// File: rtl/riscv_muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
// Op codes follow the RV funct3 encoding of the M extension.
package riscv_muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

  function automatic logic is_div(input logic [2:0] op_code);
    return op_code[2];
  endfunction

endpackage

// File: rtl/riscv_muldiv_iter.sv
// Radix-2 iterative multiply/divide: shift-add multiply and restoring divide
// share one {acc, sreg} shift pair, with sign fix-up after the last step.
module riscv_muldiv_iter
  import riscv_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state_e    state_reg;
  muldiv_op_e       op_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] sreg_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result_reg;
  logic             neg_reg;

  muldiv_op_e       op_in;
  logic             signed_a, signed_b, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf;
  logic [WIDTH-1:0] special_res;
  logic             neg_in;

  assign op_in    = muldiv_op_e'(op);
  assign signed_a = op_in inside {MULH, MULHSU, DIV, REM};
  assign signed_b = op_in inside {MULH, DIV, REM};
  assign a_neg    = signed_a && operand_a[WIDTH-1];
  assign b_neg    = signed_b && operand_b[WIDTH-1];
  assign a_mag    = a_neg ? (~operand_a + 1'b1) : operand_a;
  assign b_mag    = b_neg ? (~operand_b + 1'b1) : operand_b;
  assign div_zero = is_div(op) && (operand_b == '0);
  assign div_ovf  = (op_in == DIV || op_in == REM) &&
                    (operand_a == MIN_INT) && (operand_b == '1);

  // The remainder follows the dividend sign; everything else uses the xor.
  assign neg_in = (op_in == REM || op_in == MULHSU) ? a_neg : (a_neg ^ b_neg);

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = op[1] ? operand_a : '1;
    end else if (div_ovf) begin
      special_res = op[1] ? '0 : MIN_INT;
    end
  end

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] trial;

  assign mul_sum   = {1'b0, acc_reg} + (sreg_reg[0] ? {1'b0, b_reg} : '0);
  assign rem_shift = {acc_reg, sreg_reg[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, b_reg};

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   div_sel;
  logic [WIDTH-1:0]   fix_res;

  assign prod     = {acc_reg, sreg_reg};
  assign prod_fix = neg_reg ? (~prod + 1'b1) : prod;
  assign div_sel  = op_reg[1] ? acc_reg : sreg_reg;

  always_comb begin
    fix_res = '0;
    if (is_div(op_reg)) begin
      fix_res = neg_reg ? (~div_sel + 1'b1) : div_sel;
    end else if (op_reg == MUL) begin
      fix_res = prod_fix[WIDTH-1:0];
    end else begin
      fix_res = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      op_reg     <= MUL;
      count_reg  <= '0;
      acc_reg    <= '0;
      sreg_reg   <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      neg_reg    <= 1'b0;
    end else if (kill) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_reg <= op_in;
            if (div_zero || div_ovf) begin
              result_reg <= special_res;
              state_reg  <= DONE;
            end else begin
              acc_reg   <= '0;
              sreg_reg  <= is_div(op) ? a_mag : b_mag;
              b_reg     <= is_div(op) ? b_mag : a_mag;
              neg_reg   <= neg_in;
              count_reg <= CNT_W'(WIDTH);
              state_reg <= BUSY;
            end
          end
        end
        BUSY: begin
          if (is_div(op_reg)) begin
            if (!trial[WIDTH]) begin
              acc_reg  <= trial[WIDTH-1:0];
              sreg_reg <= {sreg_reg[WIDTH-2:0], 1'b1};
            end else begin
              acc_reg  <= rem_shift[WIDTH-1:0];
              sreg_reg <= {sreg_reg[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_reg  <= mul_sum[WIDTH:1];
            sreg_reg <= {mul_sum[0], sreg_reg[WIDTH-1:1]};
          end
          count_reg <= count_reg - CNT_W'(1);
          if (count_reg == CNT_W'(1)) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          result_reg <= fix_res;
          state_reg  <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            result_reg <= '0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;

endmodule

// File: tb/tb_riscv_muldiv_iter.sv
// Directed and random checks of riscv_muldiv_iter against a plain-arithmetic
// model of the RV32M result rules.
module tb_riscv_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic        kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  int total = 0;
  int bad = 0;

  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  riscv_muldiv_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .operand_a(operand_a), .operand_b(operand_b), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (o)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return MIN_INT;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge, measure edges-to-valid, check, then consume.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp;
    int lat, exp_lat;
    exp = ref_model(o, a, b);
    exp_lat = (o[2] && (b == 0 || (!o[0] && a == MIN_INT && b == 32'hFFFF_FFFF))) ? 1 : 34;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    op = o; operand_a = a; operand_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      lat++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, result, exp);
    $display("op=%0d a=%h b=%h result=%h expected=%h latency=%0d", o, a, b, result, exp, lat);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_result_clear"}, result, 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    logic [31:0] exp, ra, rb;
    logic [2:0] ro;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b1;

    // Multiply
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul");
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh");
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, "mulhsu");

    // Divide
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem");
    do_op(3'd5, 32'd100, 32'd7, "divu");
    do_op(3'd7, 32'd100, 32'd7, "remu");

    // Special cases
    do_op(3'd5, 32'd5, 32'd0, "divu_zero");
    do_op(3'd6, 32'h1234_5678, 32'd0, "rem_zero");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

    // Backpressure
    exp = ref_model(3'd0, 32'd123, 32'd456);
    @(negedge clk);
    op = 3'd0; operand_a = 32'd123; operand_b = 32'd456; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 200) begin
      @(negedge clk);
      seen++;
    end
    check("bp_reached_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid_hold", 32'(out_valid), 32'd1);
      check("bp_result_hold", result, exp);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    $display("op=0 a=%h b=%h result=%h backpressure held 10 cycles", 32'd123, 32'd456, result);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp_in_ready_next", 32'(in_ready), 32'd1);
    do_op(3'd5, 32'd1000, 32'd33, "bp_back_to_back");

    // Kill mid-divide
    @(negedge clk);
    op = 3'd4; operand_a = 32'd98765; operand_b = 32'd13; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    check("kill_in_ready", 32'(in_ready), 32'd1);
    check("kill_busy", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("kill_no_valid", 32'(seen), 32'd0);
    $display("op=4 a=%h b=%h killed at iteration 10", 32'd98765, 32'd13);

    // Kill together with a request in IDLE
    @(negedge clk);
    op = 3'd0; operand_a = 32'd5; operand_b = 32'd6; in_valid = 1'b1; kill = 1'b1;
    @(posedge clk);
    #1 begin in_valid = 1'b0; kill = 1'b0; end
    @(negedge clk);
    check("kill_idle_busy", 32'(busy), 32'd0);
    check("kill_idle_in_ready", 32'(in_ready), 32'd1);
    $display("op=0 a=%h b=%h request with kill ignored", 32'd5, 32'd6);

    // Reset mid-BUSY
    @(negedge clk);
    op = 3'd0; operand_a = 32'd99; operand_b = 32'd77; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    $display("op=0 a=%h b=%h reset mid-operation", 32'd99, 32'd77);
    do_op(3'd0, 32'd3, 32'd4, "mul_after_rst");

    // Random operations
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = MIN_INT; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        3: ra = 32'($urandom_range(0, 300));
        default: ;
      endcase
      do_op(ro, ra, rb, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
